// File: rtl/ralu_pkg.sv
// Shared definitions for the register-ALU slice: Q operation codes,
// named ALU function selects and the shift-sequencer state encoding.
package ralu_pkg;

  // Q register operation, driven by the control unit on q_op
  typedef enum logic [1:0] {
    Q_HOLD = 2'b00,
    Q_LOAD = 2'b01,
    Q_SHR  = 2'b10,
    Q_SHL  = 2'b11
  } q_op_e;

  // Frequently used ALU function selects (m=1 for PASS_A, m=0 for the others)
  localparam logic [3:0] S_PASS_A = 4'b1111;
  localparam logic [3:0] S_ADD    = 4'b1001;
  localparam logic [3:0] S_SUB    = 4'b0110;

  // Multi-cycle shift sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } seq_state_e;

endpackage

// File: rtl/ralu_seq_alu_core.sv
// 74181-style ALU core with active-high data and active-high carry.
// Every function is built as X + Y + carry_in, where X and Y are the two
// per-bit terms selected by s; logic mode returns ~(X ^ Y) per bit.
module alu_core
  import ralu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             carry_in,
  output logic [WIDTH-1:0] r,
  output logic             carry_out
);

  logic [WIDTH-1:0] x_term;
  logic [WIDTH-1:0] y_term;
  logic [WIDTH:0]   sum;

  // Term selection, carry chain and mode mux in one combinational block
  always_comb begin
    x_term = a | (b & {WIDTH{s[0]}}) | (~b & {WIDTH{s[1]}});
    y_term = (a & ~b & {WIDTH{s[2]}}) | (a & b & {WIDTH{s[3]}});
    sum    = {1'b0, x_term} + {1'b0, y_term} + {{WIDTH{1'b0}}, carry_in};
    if (m) begin
      r         = ~(x_term ^ y_term);
      carry_out = 1'b0;
    end else begin
      r         = sum[WIDTH-1:0];
      carry_out = sum[WIDTH];
    end
  end

endmodule

// File: rtl/ralu_seq.sv
// Register-ALU datapath slice: register file, accumulator Q, 74181 ALU
// and a start/busy/done sequencer that shifts Q one bit per cycle.
module ralu_seq
  import ralu_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             src_sel,
  input  logic [AW-1:0]    rd_adr,
  input  logic             wr,
  input  logic [AW-1:0]    wr_adr,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             carry_in,
  input  logic [1:0]       q_op,
  input  logic             isr,
  input  logic             isl,
  input  logic             start,
  input  logic             shift_dir,
  input  logic [CW-1:0]    shift_count,
  output logic             osr,
  output logic             osl,
  output logic [WIDTH-1:0] r,
  output logic             carry_out,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] reg_data [DEPTH];
  logic [CW-1:0]    start_count;
  logic [CW-1:0]    remain_reg;
  logic             dir_reg;
  logic             busy_reg;
  logic             done_reg;
  seq_state_e       state_reg;

  // Register file: one word per generate iteration, asynchronous read
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_regfile
    logic [WIDTH-1:0] cell_reg;

    // Write the ALU result when addressed; writes are blocked while busy
    always_ff @(posedge clock) begin
      if (!reset) begin
        cell_reg <= '0;
      end else if (wr && !busy_reg && (wr_adr == AW'(gi))) begin
        cell_reg <= r;
      end
    end

    assign reg_data[gi] = cell_reg;
  end

  assign operand_a = src_sel ? data_in : reg_data[rd_adr];

  alu_core #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a         (operand_a),
    .b         (q_reg),
    .s         (s),
    .m         (m),
    .carry_in  (carry_in),
    .r         (r),
    .carry_out (carry_out)
  );

  // Requested shift counts beyond the word width behave as a full-width shift
  assign start_count = (shift_count > CW'(WIDTH)) ? CW'(WIDTH) : shift_count;

  // Shift sequencer with registered busy/done flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      remain_reg <= '0;
      dir_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            dir_reg    <= shift_dir;
            busy_reg   <= 1'b1;
            remain_reg <= start_count;
            if (start_count == '0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          remain_reg <= remain_reg - 1'b1;
          if (remain_reg == CW'(1)) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Accumulator Q: sequencer shifts take over while busy, else q_op applies
  always_ff @(posedge clock) begin
    if (!reset) begin
      q_reg <= '0;
    end else if (state_reg == ST_SHIFT) begin
      if (dir_reg) begin
        q_reg <= {q_reg[WIDTH-2:0], isl};
      end else begin
        q_reg <= {isr, q_reg[WIDTH-1:1]};
      end
    end else if (state_reg == ST_IDLE) begin
      case (q_op_e'(q_op))
        Q_LOAD:  q_reg <= r;
        Q_SHR:   q_reg <= {isr, q_reg[WIDTH-1:1]};
        Q_SHL:   q_reg <= {q_reg[WIDTH-2:0], isl};
        default: q_reg <= q_reg;
      endcase
    end
  end

  assign osr  = q_reg[0];
  assign osl  = q_reg[WIDTH-1];
  assign zero = (r == '0);
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: doc/ralu_seq.md
# ralu_seq

Parametrised register-ALU datapath slice, the next generation of the 4-bit RALU in the central unit:
- generic operand width and register-file depth;
- 74181-style ALU between a selected operand and an accumulator Q;
- Q loaded or shifted one bit per cycle;
- multi-cycle barrel-free shift sequencer with start/busy/done handshake.

It sits between the control unit, which drives select/enable fields, and the data bus.

## Interface
Parameters:
- WIDTH, 4, operand/register width (≥2)
- DEPTH, 8, register-file entries (power of two, ≥2); AW = $clog2(DEPTH), CW = $clog2(WIDTH)+1

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  one clock; reset is synchronous and active-low
- data_in  in  WIDTH  external operand
- src_sel  in  1  1: operand A = data_in; 0: A = regs[rd_adr]
- rd_adr  in  AW  register-file read address
- wr  in  1  write ALU result r into regs[wr_adr] at clock edge
- wr_adr  in  AW  register-file write address
- s  in  4  ALU function select
- m  in  1  1 logic, 0 arithmetic
- carry_in  in  1  active-high carry into LSB
- q_op  in  2  00 hold, 01 load r, 10 shift right, 11 shift left
- isr / isl  in  1  serial fill bit for right / left shift
- start  in  1  begin sequenced shift (sampled when idle)
- shift_dir  in  1  sequenced shift direction, 0 right, 1 left
- shift_count  in  CW  number of single-bit shifts, 0..WIDTH
- osr / osl  out  1  Q[0] / Q[WIDTH-1], combinational
- r  out  WIDTH  ALU result, combinational
- carry_out  out  1  active-high carry from MSB (arithmetic only; 0 in logic mode)
- zero  out  1  r == 0
- busy  out  1  sequencer active
- done  out  1  one-cycle pulse at sequence end

## Operation
- ALU: B = Q. Full 74181 active-high-data function set over 16 S codes × M.
- Carry is active-high: carry_in=1 adds 1; carry_out=1 means carry/no-borrow. Examples:
  - M=0 S=1001: A+B+cin
  - M=0 S=0110: A−B−1+cin
  - M=1 S=1111: A
  - M=1 S=0000: ~A
- Width rule: r = low WIDTH bits of the WIDTH+1-bit sum; carry_out = bit WIDTH.
- Register file: DEPTH×WIDTH flops. Asynchronous read; write on edge when wr=1.
- Q register:
  - q_op=01: Q←r
  - q_op=10: Q←{isr, Q[WIDTH-1:1]}
  - q_op=11: Q←{Q[WIDTH-2:0], isl}
- Sequencer states:
  - IDLE: start=1 latches shift_dir and shift_count → SHIFT; if count=0 → DONE.
  - SHIFT: shift Q once per cycle in the latched direction (isr/isl sampled each cycle), decrement remaining count; after the last shift → DONE.
  - DONE: done=1 for one cycle → IDLE.
- busy=1 in SHIFT and DONE.
- While busy: q_op, start and wr are ignored. The register file stays readable; r stays combinational.
- shift_count > WIDTH saturates to WIDTH.

## Timing
- Reset values: regs all 0, Q=0, state IDLE, busy=0, done=0. Hence r, osr, osl and carry_out follow from Q=0 and the inputs.
- Reset has priority over everything. Asserting it mid-sequence aborts the sequence with no done pulse.
- Read-during-write to the same address returns the old value; the new value is visible the next cycle.
- wr and q_op=01 in the same cycle both capture the same r.
- Sequenced shift by N (N≥1): start sampled at edge k. Shifts happen at edges k+1..k+N. done is high during the cycle after edge k+N. start is accepted again from edge k+N+2.
- N=0: done is high the cycle after edge k; Q is unchanged.

## Structure
- Package ralu_pkg holds:
  - q_op codes (Q_HOLD, Q_LOAD, Q_SHR, Q_SHL);
  - named S codes for common functions (S_PASS_A=4'b1111, S_ADD=4'b1001, S_SUB=4'b0110);
  - sequencer state enum (ST_IDLE, ST_SHIFT, ST_DONE).
- One sub-module, alu_core: purely combinational 74181 function of (A, B, s, m, carry_in) → (r, carry_out), parametrised by WIDTH.
- Register file, Q and sequencer stay in ralu_seq.

## Test plan
Run with WIDTH=4, DEPTH=8.
- Reset and load: reset low 1 cycle; then src_sel=1, m=1, s=1111, wr=1, writing data_in 6,3,2,2 to regs 0..3 → src_sel=0 reads back 6,3,2,2; reset to regs and Q reads 0.
- Add: Q←regs[0] (6); then A=regs[1] (3), m=0, s=1001, cin=0 → r=9, carry_out=0. With A=data_in=0xA → r=0, carry_out=1, zero=1.
- Subtract: Q=6, A=3, m=0, s=0110, cin=1 → r=0xD, carry_out=0. With A=0x9 → r=0x3, carry_out=1.
- Single shifts: Q=0b1001, q_op=10, isr=1 → Q=0b1100, osr=0. Then q_op=11, isl=0 → Q=0b1000, osl=1.
- Sequencer:
  - Q=0b0001, start, shift_dir=1, count=3, isl=0 → busy 4 cycles, Q=0b1000, single done pulse.
  - count=0 → done next cycle, Q unchanged.
  - start/q_op/wr during busy ignored.
- Abort: reset low during SHIFT → Q=0, busy=0, no done pulse. Next start works normally.
